// File: rtl/ahb_sram_slave.sv
// AHB-Lite byte-wide SRAM slave: decodes a DEPTH-byte window at BASE_ADDR,
// inserts WAIT_STATES per OKAY transfer and gives a two-cycle ERROR outside the window.
module ahb_sram_slave #(
   parameter int                ADDR_W      = 21,
   parameter int                DATA_W      = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 21'h10_0000,
   parameter int                DEPTH       = 256,
   parameter int                WAIT_STATES = 0
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP
);

   localparam int                AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [3:0]        WS      = 4'(WAIT_STATES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR1 = 2'd2;
   localparam logic [1:0] S_ERR2 = 2'd3;

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_dp;
   logic              r_write;
   logic [AW-1:0]     r_addr;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [ADDR_W-1:0] w_off;
   logic              w_in_range;
   logic              w_open;
   logic              w_accept;
   logic              w_commit;

   assign w_off      = HADDR - BASE_ADDR;
   assign w_in_range = (HADDR >= BASE_ADDR) && (w_off < DEPTH_A);
   assign w_open     = (r_state == S_IDLE) || (r_state == S_ERR2);
   assign w_accept   = w_open && HSEL && HREADY && ((HTRANS == 2'b10) || (HTRANS == 2'b11));
   // r_dp marks the completing (HREADYOUT=1, OKAY) cycle of an accepted transfer
   assign w_commit   = (r_state == S_IDLE) && r_dp;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dp    <= 1'b0;
         r_write <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_dp <= 1'b0;
         case (r_state)
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= S_IDLE;
                  r_dp    <= 1'b1;
               end
            end
            S_ERR1: r_state <= S_ERR2;
            default: begin
               r_state <= S_IDLE;
               if (w_accept) begin
                  r_addr  <= w_off[AW-1:0];
                  r_write <= HWRITE;
                  if (!w_in_range) begin
                     r_state <= S_ERR1;
                  end else if (WS != 4'd0) begin
                     r_state <= S_WAIT;
                     r_cnt   <= WS;
                  end else begin
                     r_dp <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Storage is deliberately unreset; a reset clears r_dp so a pending write is dropped
   always_ff @(posedge HCLK) begin
      if (w_commit && r_write) begin
         r_mem[r_addr] <= HWDATA;
      end
   end

   assign HRDATA    = (w_commit && !r_write) ? r_mem[r_addr] : '0;
   assign HREADYOUT = (r_state != S_WAIT) && (r_state != S_ERR1);
   assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a two-wait instance, each checked
// against a byte-array model of the window plus the expected response timing.
module tb_ahb_sram_slave;

   localparam int unsigned BASE  = 32'h10_0000;
   localparam int unsigned DEPTH = 256;

   logic        clk;
   logic        rst;
   logic        hsel   [2];
   logic [20:0] haddr  [2];
   logic [1:0]  htrans [2];
   logic        hwrite [2];
   logic [7:0]  hwdata [2];
   logic [7:0]  hrdata [2];
   logic        hrdyo  [2];
   logic        hresp  [2];

   logic [7:0]  mem_m [2][DEPTH];
   bit          vld_m [2][DEPTH];
   int          n_chk;
   int          n_fail;

   ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
      .HWRITE(hwrite[0]), .HWDATA(hwdata[0]), .HREADY(hrdyo[0]),
      .HRDATA(hrdata[0]), .HREADYOUT(hrdyo[0]), .HRESP(hresp[0]));

   ahb_sram_slave #(.WAIT_STATES(2)) u_dut1 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
      .HWRITE(hwrite[1]), .HWDATA(hwdata[1]), .HREADY(hrdyo[1]),
      .HRDATA(hrdata[1]), .HREADYOUT(hrdyo[1]), .HRESP(hresp[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   // One isolated NONSEQ transfer; expected timing/data come from the window rules.
   task automatic xfer(input int d, input bit wr, input logic [20:0] a, input logic [7:0] wd);
      int unsigned ai;
      int unsigned off;
      bit          ok;
      int          exp_low;
      int          low;
      logic [7:0]  exp_rd;
      bit          rd_known;
      ai       = a;
      ok       = (ai >= BASE) && ((ai - BASE) < DEPTH);
      off      = ok ? (ai - BASE) : 0;
      exp_low  = ok ? wait_of(d) : 1;
      rd_known = 1'b1;
      exp_rd   = 8'h00;
      if (ok && !wr) begin
         rd_known = vld_m[d][off];
         exp_rd   = mem_m[d][off];
      end
      @(negedge clk);
      hsel[d]   = 1'b1;
      htrans[d] = 2'b10;
      haddr[d]  = a;
      hwrite[d] = wr;
      @(negedge clk);
      hsel[d]   = 1'b0;
      htrans[d] = 2'b00;
      haddr[d]  = 21'($urandom);
      hwrite[d] = 1'($urandom);
      hwdata[d] = wd;
      low = 0;
      while (hrdyo[d] !== 1'b1 && low < 20) begin
         check("wait_hresp", 32'(hresp[d]), 32'(!ok));
         check("wait_hrdata", 32'(hrdata[d]), 32'h0);
         low++;
         @(negedge clk);
      end
      check("low_cycles", 32'(low), 32'(exp_low));
      check("done_hresp", 32'(hresp[d]), 32'(!ok));
      if (rd_known) check("done_hrdata", 32'(hrdata[d]), 32'(exp_rd));
      if (ok && wr) begin
         mem_m[d][off] = wd;
         vld_m[d][off] = 1'b1;
      end
   endtask

   initial begin
      logic [20:0] a;
      logic [20:0] bnd [4];
      n_chk  = 0;
      n_fail = 0;
      for (int d = 0; d < 2; d++) begin
         hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00; hwrite[d] = 1'b0; hwdata[d] = '0;
         for (int k = 0; k < int'(DEPTH); k++) vld_m[d][k] = 1'b0;
      end
      bnd[0] = 21'h0F_FFFF; bnd[1] = 21'h10_0100; bnd[2] = 21'h10_00FF; bnd[3] = 21'h10_0000;

      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_hreadyout", 32'(hrdyo[d]), 32'h1);
         check("rst_hresp", 32'(hresp[d]), 32'h0);
         check("rst_hrdata", 32'(hrdata[d]), 32'h0);
      end
      rst = 1'b0;

      xfer(0, 1'b1, 21'h10_0000, 8'hAA);
      xfer(0, 1'b0, 21'h10_0000, 8'h00);
      xfer(1, 1'b1, 21'h10_0005, 8'h5C);
      xfer(1, 1'b0, 21'h10_0005, 8'h00);
      xfer(0, 1'b1, 21'h20_0000, 8'hFF);
      xfer(0, 1'b0, 21'h10_0000, 8'h00);
      xfer(1, 1'b1, 21'h20_0000, 8'hFF);
      xfer(1, 1'b0, 21'h10_0005, 8'h00);

      // BUSY and IDLE with HSEL high must not disturb state or memory
      @(negedge clk);
      hsel[0] = 1'b1; haddr[0] = 21'h10_0000; hwrite[0] = 1'b1; hwdata[0] = 8'h11;
      for (int k = 0; k < 4; k++) begin
         htrans[0] = (k < 2) ? 2'b01 : 2'b00;
         @(negedge clk);
         check("busy_hreadyout", 32'(hrdyo[0]), 32'h1);
         check("busy_hresp", 32'(hresp[0]), 32'h0);
         check("busy_hrdata", 32'(hrdata[0]), 32'h0);
      end
      hsel[0] = 1'b0; htrans[0] = 2'b00;
      xfer(0, 1'b0, 21'h10_0000, 8'h00);

      // Pipelined write then read of the same byte on the zero-wait slave
      @(negedge clk);
      hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 21'h10_0033; hwrite[0] = 1'b1;
      @(negedge clk);
      check("pipe_w_hreadyout", 32'(hrdyo[0]), 32'h1);
      htrans[0] = 2'b10; haddr[0] = 21'h10_0033; hwrite[0] = 1'b0; hwdata[0] = 8'hE1;
      @(negedge clk);
      check("pipe_r_hreadyout", 32'(hrdyo[0]), 32'h1);
      check("pipe_r_hresp", 32'(hresp[0]), 32'h0);
      check("pipe_r_hrdata", 32'(hrdata[0]), 32'hE1);
      hsel[0] = 1'b0; htrans[0] = 2'b00;
      mem_m[0][8'h33] = 8'hE1;
      vld_m[0][8'h33] = 1'b1;

      // Reset in the middle of a waited write discards it
      xfer(1, 1'b1, 21'h10_0010, 8'h3C);
      @(negedge clk);
      hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 21'h10_0010; hwrite[1] = 1'b1;
      @(negedge clk);
      hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 8'h77;
      check("midrst_pre_hreadyout", 32'(hrdyo[1]), 32'h0);
      rst = 1'b1;
      #1;
      check("midrst_hreadyout", 32'(hrdyo[1]), 32'h1);
      check("midrst_hresp", 32'(hresp[1]), 32'h0);
      check("midrst_hrdata", 32'(hrdata[1]), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      xfer(1, 1'b0, 21'h10_0010, 8'h00);

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 40; i++) begin
            case ($urandom % 8)
               6:       a = bnd[$urandom % 4];
               7:       a = 21'($urandom);
               default: a = 21'(BASE + ($urandom % DEPTH));
            endcase
            xfer(d, 1'($urandom), a, 8'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
